// File: rtl/bram_frame_pkg.sv
// bram_frame_pkg: shared state encoding for the frame buffer controller
package bram_frame_pkg;
   typedef enum logic {FILL, DRAIN} state_t;
endpackage

// File: rtl/bram_frame_buffer_ctrl.sv
// bram_frame_buffer_ctrl: store-and-forward of one stream frame through an external single-port BRAM
module bram_frame_buffer_ctrl
   import bram_frame_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_last_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_last_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_BITS-1:0]  ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   input  logic [DATA_WIDTH-1:0] ram_data_i,
   output logic [ADDR_BITS:0]    frame_len_o,
   output logic                  trunc_o
);
   localparam logic [ADDR_BITS:0] LAST_ADDR = {1'b0, {ADDR_BITS{1'b1}}};
   state_t state;
   logic [ADDR_BITS:0] wr_ptr, rd_ptr;
   logic accept, issue, fill_end;
   always_comb begin
      accept     = (state == FILL) & s_valid_i & !rst_i;
      issue      = (state == DRAIN) & (rd_ptr < frame_len_o) & (!m_valid_o | m_ready_i);
      fill_end   = accept & (s_last_i | (wr_ptr == LAST_ADDR));
      ram_en_o   = accept | issue;
      ram_we_o   = accept;
      ram_addr_o = accept ? wr_ptr[ADDR_BITS-1:0] : issue ? rd_ptr[ADDR_BITS-1:0] : '0;
   end
   assign s_ready_o  = state == FILL;
   assign ram_data_o = s_data_i;
   // the no-change RAM holds its output while ram_en_o=0, so stalled beats stay stable
   assign m_data_o   = ram_data_i;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= FILL;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         frame_len_o <= '0;
         trunc_o     <= 1'b0;
         m_valid_o   <= 1'b0;
         m_last_o    <= 1'b0;
      end else if (state == FILL) begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (fill_end) begin
            state       <= DRAIN;
            frame_len_o <= wr_ptr + 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trunc_o     <= trunc_o | !s_last_i;
         end
      end else begin
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         // a stalled beat keeps its valid/last until the sink takes it
         if (issue | m_ready_i) begin
            m_valid_o <= issue;
            m_last_o  <= issue & (rd_ptr == frame_len_o - 1'b1);
         end
         if (m_valid_o & m_ready_i & m_last_o) state <= FILL;
      end
   end
endmodule
